// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a byte-addressable data memory.
// Splits half-word and misaligned word accesses into byte beats and reassembles load results.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (we) begin
         case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            default:                ok = 1'b0;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                                ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] raw);
      logic [DATA_WIDTH-1:0] ext;
      case (f3)
         3'b000:  ext = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
         3'b001:  ext = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
         3'b010:  ext = raw;
         3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
         3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
         default: ext = {DATA_WIDTH{1'b0}};
      endcase
      return ext;
   endfunction

   state_t                state_r, state_s;
   logic [1:0]            beat_r, beat_s;
   logic [1:0]            last_r, last_s;
   logic                  word_r, word_s;
   logic                  we_r, we_s;
   logic [2:0]            funct3_r, funct3_s;
   logic [ADDR_WIDTH-1:0] addr_r, addr_s;
   logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
   logic [DATA_WIDTH-1:0] result_r, result_s;
   logic                  err_s;

   logic                  req_ready_r, req_ready_s;
   logic                  rsp_valid_r, rsp_valid_s;
   logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
   logic                  rsp_err_r, rsp_err_s;
   logic                  mem_wr_en_r, mem_wr_en_s;
   logic [2:0]            mem_funct3_r, mem_funct3_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
   logic [DATA_WIDTH-1:0] mem_wr_data_r, mem_wr_data_s;

   // Next-state, request capture, beat plan and load assembly.
   always_comb begin
      state_s  = state_r;
      beat_s   = beat_r;
      last_s   = last_r;
      word_s   = word_r;
      we_s     = we_r;
      funct3_s = funct3_r;
      addr_s   = addr_r;
      wdata_s  = wdata_r;
      result_s = result_r;
      err_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               we_s     = req_we;
               funct3_s = req_funct3;
               addr_s   = req_addr;
               wdata_s  = req_wdata;
               result_s = {DATA_WIDTH{1'b0}};
               beat_s   = 2'd0;
               word_s   = (req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00);
               case (req_funct3[1:0])
                  2'b01:   last_s = 2'd1;
                  2'b10:   last_s = (req_addr[1:0] == 2'b00) ? 2'd0 : 2'd3;
                  default: last_s = 2'd0;
               endcase
               if (f3_legal(req_we, req_funct3)) begin
                  state_s = ACCESS;
               end else begin
                  state_s = RESP;
                  err_s   = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            // Read data is combinational, so the beat's byte is latched at the edge ending it.
            if (word_r) begin
               result_s = mem_rd_data;
            end else begin
               result_s[{beat_r, 3'b000} +: 8] = mem_rd_data[7:0];
            end
            if (beat_r == last_r) begin
               state_s = RESP;
            end else begin
               beat_s = beat_r + 2'd1;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output values for the cycle that follows, so every output leaves a flop.
   always_comb begin
      req_ready_s   = (state_s == IDLE);
      rsp_valid_s   = (state_s == RESP);
      rsp_err_s     = err_s;
      rsp_rdata_s   = {DATA_WIDTH{1'b0}};
      mem_wr_en_s   = 1'b0;
      mem_funct3_s  = 3'b000;
      mem_addr_s    = {ADDR_WIDTH{1'b0}};
      mem_wr_data_s = {DATA_WIDTH{1'b0}};
      if ((state_s == RESP) && !err_s && !we_s) begin
         rsp_rdata_s = load_extend(funct3_s, result_s);
      end else begin
         rsp_rdata_s = {DATA_WIDTH{1'b0}};
      end
      if (state_s == ACCESS) begin
         mem_wr_en_s = we_s;
         mem_addr_s  = addr_s + ADDR_WIDTH'(beat_s);
         if (word_s) begin
            mem_funct3_s  = 3'b010;
            mem_wr_data_s = wdata_s;
         end else begin
            mem_funct3_s  = we_s ? 3'b000 : 3'b100;
            mem_wr_data_s = {{(DATA_WIDTH-8){1'b0}}, wdata_s[{beat_s, 3'b000} +: 8]};
         end
      end else begin
         mem_wr_en_s = 1'b0;
      end
   end

   // State, captured request and registered outputs; reset aborts any access at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         beat_r        <= 2'd0;
         last_r        <= 2'd0;
         word_r        <= 1'b0;
         we_r          <= 1'b0;
         funct3_r      <= 3'b000;
         addr_r        <= {ADDR_WIDTH{1'b0}};
         wdata_r       <= {DATA_WIDTH{1'b0}};
         result_r      <= {DATA_WIDTH{1'b0}};
         req_ready_r   <= 1'b1;
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
         rsp_err_r     <= 1'b0;
         mem_wr_en_r   <= 1'b0;
         mem_funct3_r  <= 3'b000;
         mem_addr_r    <= {ADDR_WIDTH{1'b0}};
         mem_wr_data_r <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r       <= state_s;
         beat_r        <= beat_s;
         last_r        <= last_s;
         word_r        <= word_s;
         we_r          <= we_s;
         funct3_r      <= funct3_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
         result_r      <= result_s;
         req_ready_r   <= req_ready_s;
         rsp_valid_r   <= rsp_valid_s;
         rsp_rdata_r   <= rsp_rdata_s;
         rsp_err_r     <= rsp_err_s;
         mem_wr_en_r   <= mem_wr_en_s;
         mem_funct3_r  <= mem_funct3_s;
         mem_addr_r    <= mem_addr_s;
         mem_wr_data_r <= mem_wr_data_s;
      end
   end

   assign req_ready   = req_ready_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_rdata   = rsp_rdata_r;
   assign rsp_err     = rsp_err_r;
   assign mem_wr_en   = mem_wr_en_r;
   assign mem_funct3  = mem_funct3_r;
   assign mem_addr    = mem_addr_r;
   assign mem_wr_data = mem_wr_data_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 256-byte behavioural data memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_wr_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] cyc;
   } exp_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   logic mem_clear = 1'b1;
   logic [7:0] mem [0:255];

   function automatic logic [7:0] init_byte(input logic [7:0] a);
      return a ^ 8'hA5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: synchronous writes, combinational funct3-coded reads.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_byte(8'(i));
      end else if (mem_wr_en) begin
         if (mem_funct3 == 3'b010) begin
            for (int i = 0; i < 4; i++) mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wr_data[8*i +: 8];
         end else begin
            mem[mem_addr[7:0]] <= mem_wr_data[7:0];
         end
      end
   end

   always_comb begin
      logic [7:0] a;
      a = mem_addr[7:0];
      case (mem_funct3)
         3'b010:  mem_rd_data = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
         3'b100:  mem_rd_data = {24'd0, mem[a]};
         3'b000:  mem_rd_data = {{24{mem[a][7]}}, mem[a]};
         default: mem_rd_data = 32'd0;
      endcase
   end

   exp_t mon_e;
   wr_t  mon_w;
   // Monitor: idle memory outputs, write-beat log and scoreboard pops.
   always @(negedge clk) begin
      if (req_ready || rsp_valid)
         check("idle_mem_zero", {31'd0, (mem_wr_en || mem_funct3 != 3'd0 || mem_addr != 32'd0 ||
                                         mem_wr_data != 32'd0)}, 32'd0);
      if (mem_wr_en) begin
         mon_w.f3 = mem_funct3; mon_w.addr = mem_addr; mon_w.data = mem_wr_data;
         wr_q.push_back(mon_w);
      end
      if (rsp_valid) begin
         check("ready_during_rsp", {31'd0, req_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, mon_e.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            check("rsp_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat);
      exp_t e;
      int   n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
      wr_q.delete();
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      e.rdata = exp_rdata; e.err = exp_err; e.cyc = 32'(cyc + lat);
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
      if (exp_q.size() != 0) begin
         check("rsp_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end
   endtask

   task automatic check_wr(input int idx, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data);
      if (idx >= wr_q.size()) begin
         check("wr_beat_missing", 32'(wr_q.size()), 32'(idx + 1));
      end else begin
         check("wr_funct3", {29'd0, wr_q[idx].f3}, {29'd0, f3});
         check("wr_addr", wr_q[idx].addr, addr);
         check("wr_data", wr_q[idx].data, data);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      rst_n = 1'b1;
      mem_clear = 1'b0;

      // aligned word store and load
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
      check("sw_beats", 32'(wr_q.size()), 32'd1);
      check_wr(0, 3'b010, 32'h10, 32'hDEADBEEF);
      do_req(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2);
      check("lw_no_write", 32'(wr_q.size()), 32'd0);

      // byte store, signed and unsigned byte loads
      do_req(1'b1, 3'b000, 32'h13, 32'h12345680, 32'd0, 1'b0, 2);
      check_wr(0, 3'b000, 32'h13, 32'h00000080);
      do_req(1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 2);
      do_req(1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0, 2);

      // half-word split into two byte beats
      do_req(1'b1, 3'b001, 32'h06, 32'hABCD1234, 32'd0, 1'b0, 3);
      check("sh_beats", 32'(wr_q.size()), 32'd2);
      check_wr(0, 3'b000, 32'h06, 32'h34);
      check_wr(1, 3'b000, 32'h07, 32'h12);
      do_req(1'b0, 3'b001, 32'h06, 32'd0, 32'h00001234, 1'b0, 3);
      do_req(1'b1, 3'b001, 32'h06, 32'h0000F00D, 32'd0, 1'b0, 3);
      do_req(1'b0, 3'b101, 32'h06, 32'd0, 32'h0000F00D, 1'b0, 3);
      do_req(1'b0, 3'b001, 32'h06, 32'd0, 32'hFFFFF00D, 1'b0, 3);

      // misaligned word split into four byte beats
      do_req(1'b1, 3'b010, 32'h21, 32'hA1B2C3D4, 32'd0, 1'b0, 5);
      check("msw_beats", 32'(wr_q.size()), 32'd4);
      check_wr(0, 3'b000, 32'h21, 32'hD4);
      check_wr(1, 3'b000, 32'h22, 32'hC3);
      check_wr(2, 3'b000, 32'h23, 32'hB2);
      check_wr(3, 3'b000, 32'h24, 32'hA1);
      do_req(1'b0, 3'b010, 32'h21, 32'd0, 32'hA1B2C3D4, 1'b0, 5);
      do_req(1'b0, 3'b010, 32'h20, 32'd0, {24'hB2C3D4, init_byte(8'h20)}, 1'b0, 2);

      // illegal funct3 codes
      do_req(1'b0, 3'b011, 32'h40, 32'd0, 32'd0, 1'b1, 1);
      do_req(1'b0, 3'b111, 32'h40, 32'd0, 32'd0, 1'b1, 1);
      do_req(1'b1, 3'b100, 32'h40, 32'h11223344, 32'd0, 1'b1, 1);
      check("err_store_no_write", 32'(wr_q.size()), 32'd0);
      check("err_store_mem", {24'd0, mem[8'h40]}, {24'd0, init_byte(8'h40)});

      // half-word wrapping past the top of the address space
      do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h00005AA5, 32'd0, 1'b0, 3);
      check_wr(0, 3'b000, 32'hFFFFFFFF, 32'hA5);
      check_wr(1, 3'b000, 32'h00000000, 32'h5A);
      do_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'd0, 32'h00005AA5, 1'b0, 3);

      // reset during beat 2 of a misaligned store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h31; req_wdata = 32'h55667788;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      check("beat2_wr_en", {31'd0, mem_wr_en}, 32'd1);
      check("beat2_addr", mem_addr, 32'h33);
      rst_n = 1'b0;
      #1;
      check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      rst_n = 1'b1;
      check("abort_byte31", {24'd0, mem[8'h31]}, 32'h88);
      check("abort_byte32", {24'd0, mem[8'h32]}, 32'h77);
      check("abort_byte33", {24'd0, mem[8'h33]}, {24'd0, init_byte(8'h33)});
      check("abort_byte34", {24'd0, mem[8'h34]}, {24'd0, init_byte(8'h34)});
      do_req(1'b0, 3'b010, 32'h30, 32'd0,
             {init_byte(8'h33), 8'h77, 8'h88, init_byte(8'h30)}, 1'b0, 2);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
